// File: rtl/rx_frame_fsm.sv
// ----------------------------------------------------------------------------
// rx_frame_fsm
// Receive framing controller for an oversampled UART-style serial line.
// Follows one frame (start, 8 data bits, optional parity, stop) using the
// acquisition ticks from the baud-rate module. Each bit is sampled at tick
// ACQ_POINT of its period. The received byte and the error flags are
// published together with a one-clk Done_o pulse.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   AcqSig_i       one-clk acquisition tick (OVERSAMPLE per bit period)
//   Rx_Synch_i     start-edge sync pulse, honoured only in IDLE
//   RxBit_i        synchronized RX line level
//   p_ParityEn_i   1 = parity bit present
//   p_ParityOdd_i  1 = odd parity, 0 = even
//   p_BigEnd_i     1 = MSB first, 0 = LSB first
//   State_o        one-hot state
//   BitCounter_o   index of the current data bit (0 outside DATABITS)
//   Data_o         last received byte
//   Done_o         one-clk frame-complete pulse
//   ParityErr_o    parity error of the last frame
//   FrameErr_o     stop-bit error of the last frame
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for Rx_Synch_i
// STARTBIT  | start bit; a high sample is a false start
// DATABITS  | 8 data bits, stored at each sample tick
// PARITYBIT | parity bit checked at its sample tick
// STOPBIT   | stop bit; leaves at the sample tick so the next edge can resync
// ----------------------------------------------------------------------------
module rx_frame_fsm #(
   parameter int OVERSAMPLE = 16,
   parameter int ACQ_POINT  = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       AcqSig_i,
   input  logic       Rx_Synch_i,
   input  logic       RxBit_i,
   input  logic       p_ParityEn_i,
   input  logic       p_ParityOdd_i,
   input  logic       p_BigEnd_i,
   output logic [4:0] State_o,
   output logic [3:0] BitCounter_o,
   output logic [7:0] Data_o,
   output logic       Done_o,
   output logic       ParityErr_o,
   output logic       FrameErr_o
);

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_START = 5'b00010,
      S_DATA  = 5'b00100,
      S_PAR   = 5'b01000,
      S_STOP  = 5'b10000
   } state_t;

   localparam logic [3:0] ACQ_TC = 4'(ACQ_POINT);
   localparam logic [3:0] END_TC = 4'(OVERSAMPLE - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_tick;
   logic [3:0] r_bitcnt;
   logic [7:0] r_shift;
   logic       r_par;
   logic       r_perr_int;
   logic       r_par_en;
   logic       r_par_odd;
   logic       r_big_end;
   logic [7:0] r_data;
   logic       r_done;
   logic       r_perr;
   logic       r_ferr;

   logic       w_sample;
   logic       w_end;
   logic       w_start;
   logic       w_done;
   logic [2:0] w_idx;

   assign w_sample = AcqSig_i && (r_tick == ACQ_TC);
   assign w_end    = AcqSig_i && (r_tick == END_TC);
   assign w_start  = (r_state == S_IDLE) && Rx_Synch_i;
   assign w_done   = (r_state == S_STOP) && w_sample;
   assign w_idx    = r_big_end ? (3'd7 - r_bitcnt[2:0]) : r_bitcnt[2:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (Rx_Synch_i) w_next = S_START;
         S_START: begin
            if (w_sample && RxBit_i) w_next = S_IDLE;
            else if (w_end)          w_next = S_DATA;
         end
         S_DATA:  if (w_end && (r_bitcnt == 4'd7)) w_next = r_par_en ? S_PAR : S_STOP;
         S_PAR:   if (w_end) w_next = S_STOP;
         S_STOP:  if (w_sample) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tick     <= 4'd0;
         r_bitcnt   <= 4'd0;
         r_shift    <= 8'h00;
         r_par      <= 1'b0;
         r_perr_int <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_big_end  <= 1'b0;
         r_data     <= 8'h00;
         r_done     <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= w_done;

         // The tick count starts at 1 because the sync pulse already marks
         // the first tick of the start bit.
         if (r_state == S_IDLE) begin
            if (Rx_Synch_i) r_tick <= 4'd1;
         end else if (AcqSig_i) begin
            r_tick <= r_tick + 4'd1;
         end

         if (w_start) begin
            r_par_en  <= p_ParityEn_i;
            r_par_odd <= p_ParityOdd_i;
            r_big_end <= p_BigEnd_i;
         end

         if (r_state != S_DATA) begin
            r_bitcnt <= 4'd0;
         end else if (w_end) begin
            r_bitcnt <= (r_bitcnt == 4'd7) ? 4'd0 : r_bitcnt + 4'd1;
         end

         if ((r_state == S_DATA) && w_sample) begin
            r_shift[w_idx] <= RxBit_i;
            r_par          <= (r_bitcnt == 4'd0) ? RxBit_i : (r_par ^ RxBit_i);
         end

         if ((r_state == S_PAR) && w_sample) begin
            r_perr_int <= ((r_par ^ RxBit_i) != r_par_odd);
         end

         // Byte and flags are staged internally and published together
         // with Done_o so the outputs stay stable for a whole frame.
         if (w_done) begin
            r_data <= r_shift;
            r_ferr <= !RxBit_i;
            r_perr <= r_par_en && r_perr_int;
         end
      end
   end

   assign State_o      = r_state;
   assign BitCounter_o = r_bitcnt;
   assign Data_o       = r_data;
   assign Done_o       = r_done;
   assign ParityErr_o  = r_perr;
   assign FrameErr_o   = r_ferr;

endmodule

// File: tb/tb_rx_frame_fsm.sv
module tb_rx_frame_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       AcqSig_i = 1'b0;
   logic       Rx_Synch_i = 1'b0;
   logic       RxBit_i = 1'b1;
   logic       p_ParityEn_i = 1'b0;
   logic       p_ParityOdd_i = 1'b0;
   logic       p_BigEnd_i = 1'b0;
   logic [4:0] State_o;
   logic [3:0] BitCounter_o;
   logic [7:0] Data_o;
   logic       Done_o;
   logic       ParityErr_o;
   logic       FrameErr_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_done = 0;
   int exp_done = 0;
   logic [39:0] hist;
   logic [4:0]  last_state;

   rx_frame_fsm #(.OVERSAMPLE(16), .ACQ_POINT(7)) dut (
      .clk(clk), .rst(rst), .AcqSig_i(AcqSig_i), .Rx_Synch_i(Rx_Synch_i),
      .RxBit_i(RxBit_i), .p_ParityEn_i(p_ParityEn_i), .p_ParityOdd_i(p_ParityOdd_i),
      .p_BigEnd_i(p_BigEnd_i), .State_o(State_o), .BitCounter_o(BitCounter_o),
      .Data_o(Data_o), .Done_o(Done_o), .ParityErr_o(ParityErr_o), .FrameErr_o(FrameErr_o)
   );

   always #5 clk = ~clk;

   // Observer: counts Done_o pulses and records the sequence of states.
   always @(posedge clk) begin
      #1;
      if (Done_o === 1'b1) n_done = n_done + 1;
      if (State_o !== last_state) begin
         hist = {hist[34:0], State_o};
         last_state = State_o;
      end
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_hist();
      hist = 40'h0;
      hist[4:0] = 5'b00001;
      last_state = 5'b00001;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) AcqSig_i = 1'b1;
         @(negedge clk) AcqSig_i = 1'b0;
      end
   endtask

   task automatic synch();
      @(negedge clk) Rx_Synch_i = 1'b1;
      @(negedge clk) Rx_Synch_i = 1'b0;
   endtask

   task automatic bit_period(input logic b, input int n);
      RxBit_i = b;
      tick(n);
   endtask

   task automatic idle(input int n);
      RxBit_i = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // serial[i] is the i-th bit on the line
   task automatic data_bits(input logic [7:0] serial);
      for (int i = 0; i < 8; i++) bit_period(serial[i], 16);
   endtask

   initial begin
      clear_hist();
      repeat (3) @(negedge clk);
      check("rst_state", 40'(State_o), 40'h01);
      check("rst_bitcnt", 40'(BitCounter_o), 40'h0);
      check("rst_data", 40'(Data_o), 40'h00);
      check("rst_done", 40'(Done_o), 40'h0);
      check("rst_perr", 40'(ParityErr_o), 40'h0);
      check("rst_ferr", 40'(FrameErr_o), 40'h0);
      rst = 1'b1;
      idle(3);

      // Frame 0xA5, no parity, LSB first
      clear_hist();
      synch();
      check("a5_startbit_state", 40'(State_o), 40'h02);
      check("a5_startbit_bitcnt", 40'(BitCounter_o), 40'h0);
      bit_period(1'b0, 15);
      check("a5_databits_state", 40'(State_o), 40'h04);
      data_bits(8'hA5);
      check("a5_data_held_midframe", 40'(Data_o), 40'h00);
      bit_period(1'b1, 8);
      exp_done++;
      check("a5_done_count", 40'(n_done), 40'(exp_done));
      check("a5_data", 40'(Data_o), 40'hA5);
      check("a5_perr", 40'(ParityErr_o), 40'h0);
      check("a5_ferr", 40'(FrameErr_o), 40'h0);
      check("a5_state_seq", hist[24:0], {5'b00001, 5'b00010, 5'b00100, 5'b10000, 5'b00001});
      idle(4);
      check("a5_done_single", 40'(n_done), 40'(exp_done));

      // 0x03 even parity, parity bit 1; config changed mid-frame is ignored
      p_ParityEn_i = 1'b1; p_ParityOdd_i = 1'b0;
      clear_hist();
      synch();
      p_ParityEn_i = 1'b0; p_ParityOdd_i = 1'b1;
      bit_period(1'b0, 15);
      data_bits(8'h03);
      check("par1_parity_state", 40'(State_o), 40'h08);
      bit_period(1'b1, 16);
      bit_period(1'b1, 8);
      exp_done++;
      check("par1_done_count", 40'(n_done), 40'(exp_done));
      check("par1_data", 40'(Data_o), 40'h03);
      check("par1_perr", 40'(ParityErr_o), 40'h1);
      check("par1_state_seq", hist[29:0],
            {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001});
      idle(4);

      // Same frame with parity bit 0
      p_ParityEn_i = 1'b1; p_ParityOdd_i = 1'b0;
      synch();
      bit_period(1'b0, 15);
      data_bits(8'h03);
      bit_period(1'b0, 16);
      bit_period(1'b1, 8);
      exp_done++;
      check("par0_done_count", 40'(n_done), 40'(exp_done));
      check("par0_perr", 40'(ParityErr_o), 40'h0);
      idle(4);

      // 0x55 with stop bit 0
      p_ParityEn_i = 1'b0;
      synch();
      bit_period(1'b0, 15);
      data_bits(8'h55);
      bit_period(1'b0, 8);
      exp_done++;
      check("ferr_done_count", 40'(n_done), 40'(exp_done));
      check("ferr_data", 40'(Data_o), 40'h55);
      check("ferr_flag", 40'(FrameErr_o), 40'h1);
      check("ferr_perr_noparity", 40'(ParityErr_o), 40'h0);
      idle(4);

      // False start: line high at the start-bit sample tick
      synch();
      bit_period(1'b1, 6);
      check("false_before_sample", 40'(State_o), 40'h02);
      bit_period(1'b1, 1);
      check("false_state", 40'(State_o), 40'h01);
      idle(4);
      check("false_no_done", 40'(n_done), 40'(exp_done));
      check("false_data_kept", 40'(Data_o), 40'h55);
      check("false_ferr_kept", 40'(FrameErr_o), 40'h1);

      // Big-endian 1,0,1,0,0,1,0,1 with stray sync pulses in DATABITS
      p_BigEnd_i = 1'b1;
      synch();
      p_BigEnd_i = 1'b0;
      bit_period(1'b0, 15);
      bit_period(1'b1, 16); bit_period(1'b0, 16); bit_period(1'b1, 16);
      synch();
      check("be_sync_ignored_state", 40'(State_o), 40'h04);
      check("be_bitcnt3", 40'(BitCounter_o), 40'h3);
      bit_period(1'b0, 16); bit_period(1'b0, 16);
      synch();
      bit_period(1'b1, 16); bit_period(1'b0, 16); bit_period(1'b1, 16);
      bit_period(1'b1, 8);
      exp_done++;
      check("be_done_count", 40'(n_done), 40'(exp_done));
      check("be_data", 40'(Data_o), 40'hA5);
      check("be_ferr", 40'(FrameErr_o), 40'h0);
      idle(4);

      // Reset while BitCounter_o = 4, then a clean 0x3C frame
      synch();
      bit_period(1'b0, 15);
      for (int i = 0; i < 4; i++) bit_period(1'b0, 16);
      bit_period(1'b1, 3);
      check("mid_bitcnt4", 40'(BitCounter_o), 40'h4);
      @(negedge clk) rst = 1'b0;
      #1;
      check("mid_rst_state", 40'(State_o), 40'h01);
      check("mid_rst_bitcnt", 40'(BitCounter_o), 40'h0);
      check("mid_rst_data", 40'(Data_o), 40'h00);
      check("mid_rst_done", 40'(Done_o), 40'h0);
      check("mid_rst_perr", 40'(ParityErr_o), 40'h0);
      check("mid_rst_ferr", 40'(FrameErr_o), 40'h0);
      @(negedge clk) rst = 1'b1;
      tick(40);
      check("mid_wait_idle", 40'(State_o), 40'h01);
      check("mid_no_done", 40'(n_done), 40'(exp_done));
      synch();
      bit_period(1'b0, 15);
      data_bits(8'h3C);
      bit_period(1'b1, 8);
      exp_done++;
      check("post_rst_done_count", 40'(n_done), 40'(exp_done));
      check("post_rst_data", 40'(Data_o), 40'h3C);
      check("post_rst_ferr", 40'(FrameErr_o), 40'h0);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
